// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: mode state encoding and default tick rates.
package stopwatch_pkg;

  // Mode controller states. The encoding is visible on the state output
  // and is used by the display block.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10,
    ADJUST = 2'b11
  } sw_state_e;

  // Default dividers for a 100 MHz system clock:
  // 1 Hz run tick and 2 Hz adjust tick.
  localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;
  localparam int unsigned ADJ_DIV_DEFAULT  = 50_000_000;

  // A pause pulse toggles between running and paused.
  // IDLE starts the run. ADJUST is never left by a pause pulse.
  function automatic sw_state_e pause_next(input sw_state_e cur);
    sw_state_e nxt;
    nxt = cur;
    case (cur)
      IDLE:    nxt = RUN;
      RUN:     nxt = PAUSE;
      PAUSE:   nxt = RUN;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter that emits a registered one-cycle tick
// each time it wraps. The count only advances while en is high, so a
// partial period is kept across disabled intervals. sclr restarts the
// period from zero and has priority over en.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic src_clk,
  input  logic src_rst,
  input  logic en,
  input  logic sclr,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count and tick: wrap at DIV-1 and flag the wrap for one cycle.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (sclr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Count and tick registers.
  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller. Turns debounced button pulses and the
// synchronized adjust/select levels into the run level, a clear strobe
// and the run/adjust count enables for the BCD time counter.
//
// Input and output signalling: pause_pls and clr_pls are one-cycle
// pulses. Every high cycle is a separate event. adj and sel are levels.
// clr, tick and adj_tick are one-cycle pulses. running, adj_sel and state
// are levels. All outputs are registered and change on the edge that
// samples the causing event.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned ADJ_DIV  = ADJ_DIV_DEFAULT
) (
  input  logic       src_clk,
  input  logic       src_rst,
  input  logic       pause_pls,
  input  logic       clr_pls,
  input  logic       adj,
  input  logic       sel,
  output logic       running,
  output logic       clr,
  output logic       tick,
  output logic       adj_tick,
  output logic       adj_sel,
  output logic [1:0] state
);

  sw_state_e state_q, state_d;
  logic      running_q;
  logic      clr_q;
  logic      adj_sel_q;

  logic      run_en;
  logic      run_sclr;
  logic      adj_en;
  logic      adj_sclr;

  // Next-state selection. Priority is clear, then adjust, then pause.
  always_comb begin
    state_d = state_q;
    if (clr_pls) begin
      state_d = adj ? ADJUST : IDLE;
    end else if (adj) begin
      state_d = ADJUST;
    end else if (state_q == ADJUST) begin
      state_d = PAUSE;
    end else if (pause_pls) begin
      state_d = pause_next(state_q);
    end
  end

  // Dividers run only in their own state, on the current registered state.
  // A tick already due on the edge that leaves RUN is therefore still
  // issued. Clear restarts both dividers. Entering ADJUST restarts the
  // adjust divider so that its first tick is a full period away.
  always_comb begin
    run_en   = (state_q == RUN);
    run_sclr = clr_pls;
    adj_en   = (state_q == ADJUST);
    adj_sclr = clr_pls | (adj & (state_q != ADJUST));
  end

  // Mode FSM with its registered outputs.
  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      clr_q     <= 1'b0;
      adj_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      clr_q     <= clr_pls;
      adj_sel_q <= sel;
    end
  end

  tick_divider #(
    .DIV (TICK_DIV)
  ) u_run_div (
    .src_clk (src_clk),
    .src_rst (src_rst),
    .en      (run_en),
    .sclr    (run_sclr),
    .tick    (tick)
  );

  tick_divider #(
    .DIV (ADJ_DIV)
  ) u_adj_div (
    .src_clk (src_clk),
    .src_rst (src_rst),
    .en      (adj_en),
    .sclr    (adj_sclr),
    .tick    (adj_tick)
  );

  assign running = running_q;
  assign clr     = clr_q;
  assign adj_sel = adj_sel_q;
  assign state   = state_q;

endmodule
